dmem_responder: RTL
===================

# dmem_responder

Data-memory responder for the npc-riscv64 core: the memory-side end of the load/store path driven by the controller's `mem_r`/`mem_w` strobes. It accepts one request at a time, models a fixed multi-cycle access latency with a stall back to the core, and performs sized, aligned reads and writes on an internal 64-bit-word RAM. Load results are sign- or zero-extended per `func3`; illegal requests are flagged as faults.

## Interface
- `DEPTH_WORDS`, default 1024: number of 64-bit RAM words; must be a power of 2.
- `LATENCY`, default 2: cycles from request presentation to `resp_valid`; must be ≥1.
- `BASE_ADDR`, default 64'h8000_0000: byte address of RAM word 0.

- `clk`  in  1  the only clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_r`  in  1  load request from the controller.
- `mem_w`  in  1  store request from the controller.
- `func3`  in  3  access size and signedness (instruction funct3).
- `addr`  in  64  byte address.
- `wdata`  in  64  store data; the low bytes are used.
- `req_ready`  out  1  the responder is idle and can accept a request.
- `resp_valid`  out  1  one-cycle pulse: the transaction is complete.
- `rdata`  out  64  extended load data; valid while `resp_valid` is high.
- `fault`  out  1  the completed transaction was illegal; valid while `resp_valid` is high.
- `stall`  out  1  holds the core's PC while a request is outstanding.

## Operation
- The request is `mem_r | mem_w`.
- States: IDLE, WAIT, RESP.
  - IDLE: `req_ready`=1.
    - A request is accepted at the edge. The block latches `addr`, `func3`, `wdata`, `mem_r` and `mem_w`.
    - If LATENCY=1, the next state is RESP and the access is performed at this edge.
    - Otherwise the next state is WAIT, with `cnt`=LATENCY-2.
  - WAIT: input changes are ignored.
    - If `cnt`==0, the next state is RESP and the access uses the latched fields at this edge.
    - Otherwise `cnt` decrements.
  - RESP: `resp_valid`=1 and `req_ready`=0; the next state is always IDLE.
    - The core retires during this cycle, so a held request is never accepted twice.
- `stall` = request & ~`resp_valid`. It is combinational and is forced to 0 while `rst` is high.
- Address decoding:
  - `off` = `addr` - BASE_ADDR.
  - Word index = `off[log2(DEPTH_WORDS)+2:3]`.
  - Byte lane = `addr[2:0]`.
- Loads (func3):
  - 000 LB, 001 LH, 010 LW, 011 LD: sign-extended to 64 bits.
  - 100 LBU, 101 LHU, 110 LWU: zero-extended.
- Stores (func3): 000 SB, 001 SH, 010 SW, 011 SD. Only the addressed bytes are written, using the low bytes of `wdata` placed at the lane; the other bytes of the word are unchanged.
- `fault`=1 when any of these holds:
  - `mem_r` and `mem_w` are both high;
  - `func3` is invalid for the operation (load 111; store ≥100);
  - the address is misaligned for the size (addr[0] for half, addr[1:0] for word, addr[2:0] for double);
  - `off` ≥ DEPTH_WORDS*8, including `addr` < BASE_ADDR.
- A faulting transaction keeps full latency, writes nothing, and returns `rdata`=0.
- RAM contents are not cleared by reset.

## Timing
- A request first appears in cycle 0.
  - `stall`=1 in cycles 0..LATENCY-1.
  - `resp_valid`, `rdata` and `fault` are valid in cycle LATENCY.
  - The next request can be accepted no earlier than cycle LATENCY+1.
- `rdata` and `fault` are registered at the access edge.
  - They hold their value after RESP until the next access edge.
  - They are only meaningful while `resp_valid` is high.
- A store is visible to a load that completes at a later access edge (read-after-write with no gap).
- Reset values, for any state including mid-WAIT: state=IDLE, `cnt`=0, `resp_valid`=0, `rdata`=0, `fault`=0. A pending store is dropped.
- During the reset cycle `req_ready`=0 and `stall`=0. The cycle after `rst` deasserts, `req_ready`=1.

## Test plan
- SD then LD, LATENCY=2:
  - Stimulus: SD of 64'h1122_3344_5566_7788 to 0x8000_0010, then LD from 0x8000_0010.
  - Required: `stall` high for 2 cycles per access; LD `rdata`=64'h1122334455667788; `fault`=0.
- Sized loads over the same word:
  - LB of 0x8000_0010 → 64'h0000_0000_0000_0088 is wrong; the required value is 64'hFFFF_FFFF_FFFF_FF88.
  - LBU of 0x8000_0010 → 64'h88.
  - LH of 0x8000_0016 → 64'h1122.
  - LWU of 0x8000_0014 → 64'h11223344.
- SB merge:
  - Stimulus: SB of wdata=0xAB to 0x8000_0013, then LD from 0x8000_0010.
  - Required: 64'h11223344AB667788.
- Faults; each must give `resp_valid` after LATENCY cycles, `fault`=1, `rdata`=0 and no RAM change:
  - LW from 0x8000_0012 (misaligned).
  - SD to 0x7FFF_FFF8 (below BASE_ADDR).
  - `mem_r` and `mem_w` asserted together.
- Reset mid-operation:
  - Stimulus: assert `rst` during WAIT of an SD to 0x8000_0010 with 64'hDEAD.
  - Required: the next cycle shows `resp_valid`=0 and `stall`=0; a subsequent LD from 0x8000_0010 returns the old value.
- LATENCY=1 back-to-back:
  - Stimulus: alternating SW/LW requests.
  - Required: `resp_valid` in each request's cycle 1, then IDLE; a held request produces exactly one response.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, models a fixed access
// latency with a stall to the core, and performs sized aligned accesses on a word RAM.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic [2:0]  func3,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [63:0] rdata,
    output logic        fault,
    output logic        stall
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY >= 2) ? (LATENCY - 2) : 0);
    localparam logic [63:0] SPAN = 64'(DEPTH_WORDS) * 64'd8;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   addr_q, addr_d;
    logic [2:0]    func3_q, func3_d;
    logic [63:0]   wdata_q, wdata_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [63:0]   rdata_q, rdata_d;
    logic          fault_q, fault_d;
    logic [63:0]   mem_q [DEPTH_WORDS];

    logic          req;
    logic          acc_en;
    logic          acc_sel_in;
    logic [63:0]   a_addr;
    logic [2:0]    a_f3;
    logic [63:0]   a_wdata;
    logic          a_rd;
    logic          a_wr;
    logic [63:0]   off;
    logic [AW-1:0] idx;
    logic [2:0]    lane;
    logic [63:0]   word;
    logic [63:0]   shifted;
    logic [63:0]   load_val;
    logic [7:0]    bmask;
    logic [63:0]   wmask;
    logic [63:0]   new_word;
    logic          misal;
    logic          bad_f3;
    logic          acc_fault;
    logic          we;

    assign req = mem_r | mem_w;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        func3_d    = func3_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        acc_en     = 1'b0;
        acc_sel_in = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = addr;
                    func3_d = func3;
                    wdata_d = wdata;
                    rd_d    = mem_r;
                    wr_d    = mem_w;
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        acc_en     = 1'b1;
                        acc_sel_in = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    acc_en  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With LATENCY=1 the access happens at the accept edge, so it uses the live inputs.
    always_comb begin
        a_addr  = acc_sel_in ? addr  : addr_q;
        a_f3    = acc_sel_in ? func3 : func3_q;
        a_wdata = acc_sel_in ? wdata : wdata_q;
        a_rd    = acc_sel_in ? mem_r : rd_q;
        a_wr    = acc_sel_in ? mem_w : wr_q;

        off     = a_addr - BASE_ADDR;
        idx     = off[AW+2:3];
        lane    = a_addr[2:0];
        word    = mem_q[idx];
        shifted = word >> {lane, 3'b000};

        case (a_f3[1:0])
            2'd0:    begin misal = 1'b0;     bmask = 8'h01; end
            2'd1:    begin misal = lane[0];  bmask = 8'h03; end
            2'd2:    begin misal = |lane[1:0]; bmask = 8'h0F; end
            default: begin misal = |lane;    bmask = 8'hFF; end
        endcase
        bmask = bmask << lane;
        wmask = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            wmask[i*8 +: 8] = {8{bmask[i]}};
        end
        new_word = (word & ~wmask) | ((a_wdata << {lane, 3'b000}) & wmask);

        bad_f3    = a_rd ? (a_f3 == 3'b111) : a_f3[2];
        acc_fault = (a_rd & a_wr) | bad_f3 | misal | (off >= SPAN);

        case (a_f3)
            3'b000:  load_val = {{56{shifted[7]}},  shifted[7:0]};
            3'b001:  load_val = {{48{shifted[15]}}, shifted[15:0]};
            3'b010:  load_val = {{32{shifted[31]}}, shifted[31:0]};
            3'b011:  load_val = shifted;
            3'b100:  load_val = {56'd0, shifted[7:0]};
            3'b101:  load_val = {48'd0, shifted[15:0]};
            3'b110:  load_val = {32'd0, shifted[31:0]};
            default: load_val = '0;
        endcase

        we      = acc_en & a_wr & ~acc_fault & ~rst;
        rdata_d = rdata_q;
        fault_d = fault_q;
        if (acc_en) begin
            fault_d = acc_fault;
            rdata_d = (acc_fault | ~a_rd) ? '0 : load_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            func3_q <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            func3_q <= func3_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= new_word;
        end
    end

    assign req_ready  = (state_q == IDLE) & ~rst;
    assign resp_valid = (state_q == RESP);
    assign stall      = req & ~resp_valid & ~rst;
    assign rdata      = rdata_q;
    assign fault      = fault_q;

endmodule
